// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache takes the slave modport; the datapath/controller environment takes master.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with same-cycle hits,
// single-word miss fill through the memory controller and saturating hit/miss counters.
module icache #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  icache_if.slave          bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             dbg_state_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  // Handshakes: the datapath holds imemREN/imemaddr and treats imemload as valid only
  // while ihit=1. Toward the controller iREN is the request (held with a stable iaddr),
  // and the request completes, with iload valid, in the cycle iwait=0.
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [31:0]        word_q [SETS];
  logic [29:0]        maddr_q, maddr_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]   tag, fill_tag;
  logic               lookup_hit, fill;
  logic               unused_addr_lsb;

  assign idx             = bus.imemaddr[IDX_W+1:2];
  assign tag             = bus.imemaddr[31:IDX_W+2];
  assign fill_idx        = maddr_q[IDX_W-1:0];
  assign fill_tag        = maddr_q[29:IDX_W];
  assign unused_addr_lsb = ^bus.imemaddr[1:0];

  assign lookup_hit   = bus.imemREN & valid_q[idx] & (tag_q[idx] == tag);
  assign bus.imemload = word_q[idx];
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
  assign dbg_state_o  = (state_q == FETCH);

  always_comb begin
    state_d    = state_q;
    maddr_d    = maddr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill       = 1'b0;
    bus.ihit   = 1'b0;
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;
    case (state_q)
      IDLE: begin
        bus.ihit = lookup_hit;
        if (lookup_hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (bus.imemREN) begin
          maddr_d = bus.imemaddr[31:2];
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d = FETCH;
        end
      end
      FETCH: begin
        // The controller is committed once asked, so the fill finishes regardless
        // of what the datapath does meanwhile.
        bus.iREN  = 1'b1;
        bus.iaddr = {maddr_q, 2'b00};
        if (!bus.iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      maddr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      maddr_q    <= maddr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill && nRST) begin
      tag_q[fill_idx]  <= fill_tag;
      word_q[fill_idx] <= bus.iload;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, hit streak/saturation sequence and random
// traffic, all checked against an address-level model of the cache contents.
module tb_icache;
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  icache_if bus ();
  icache_if bus_s ();
  assign bus_s.imemREN  = bus.imemREN;
  assign bus_s.imemaddr = bus.imemaddr;
  assign bus_s.iwait    = bus.iwait;
  assign bus_s.iload    = bus.iload;

  logic [31:0] hit_cnt, miss_cnt;
  logic [3:0]  hit_cnt_s, miss_cnt_s;
  logic        dbg, dbg_s;

  icache #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus.slave),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state_o(dbg)
  );
  icache #(.SETS(16), .CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .bus(bus_s.slave),
    .hit_cnt(hit_cnt_s), .miss_cnt(miss_cnt_s), .dbg_state_o(dbg_s)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: cache contents held as full word addresses per frame.
  bit          m_valid [16];
  logic [31:0] m_addr  [16];
  logic [31:0] m_data  [16];
  bit          m_fetch;
  logic [31:0] m_faddr;
  longint      m_hits, m_misses;

  bit          cur_rst, cur_ren, cur_w;
  logic [31:0] cur_addr, cur_ld;
  bit          e_hit;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] sat4(input longint v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_fetch  = 1'b0;
    m_faddr  = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic apply(input bit rst_n, input bit ren, input logic [31:0] addr,
                       input bit w, input logic [31:0] ld);
    cur_rst = rst_n; cur_ren = ren; cur_addr = addr; cur_w = w; cur_ld = ld;
    nRST = rst_n;
    bus.imemREN = ren;
    bus.imemaddr = addr;
    bus.iwait = w;
    bus.iload = ld;
    @(negedge CLK);
  endtask

  task automatic check_model();
    int          idx;
    logic [31:0] wa;
    logic        e_iren;
    logic [31:0] e_iaddr;
    idx = int'(cur_addr[5:2]);
    wa  = {cur_addr[31:2], 2'b00};
    if (m_fetch) begin
      e_hit = 1'b0; e_iren = 1'b1; e_iaddr = m_faddr;
    end else begin
      e_hit = cur_ren && m_valid[idx] && (m_addr[idx] == wa);
      e_iren = 1'b0; e_iaddr = '0;
    end
    chk("ihit", {31'b0, bus.ihit}, {31'b0, e_hit});
    chk("iREN", {31'b0, bus.iREN}, {31'b0, e_iren});
    chk("iaddr", bus.iaddr, e_iaddr);
    if (e_hit) chk("imemload", bus.imemload, m_data[idx]);
    chk("hit_cnt", hit_cnt, m_hits[31:0]);
    chk("miss_cnt", miss_cnt, m_misses[31:0]);
    chk("hit_cnt_sat", {28'b0, hit_cnt_s}, sat4(m_hits));
    chk("miss_cnt_sat", {28'b0, miss_cnt_s}, sat4(m_misses));
    chk("dbg_state", {31'b0, dbg}, {31'b0, m_fetch});
  endtask

  task automatic advance();
    int fidx;
    if (!cur_rst) begin
      model_reset();
    end else if (m_fetch) begin
      if (!cur_w) begin
        fidx = int'(m_faddr[5:2]);
        m_valid[fidx] = 1'b1;
        m_addr[fidx]  = m_faddr;
        m_data[fidx]  = cur_ld;
        m_fetch = 1'b0;
      end
    end else if (e_hit) begin
      m_hits++;
    end else if (cur_ren) begin
      m_misses++;
      m_faddr = {cur_addr[31:2], 2'b00};
      m_fetch = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle(input bit rst_n, input bit ren, input logic [31:0] addr,
                       input bit w, input logic [31:0] ld);
    apply(rst_n, ren, addr, w, ld);
    check_model();
    advance();
  endtask

  typedef struct {
    bit          nrst;
    bit          ren;
    logic [31:0] addr;
    bit          w;
    logic [31:0] ld;
    bit          x_ihit;
    bit          x_iren;
    logic [31:0] x_iaddr;
    logic [31:0] x_load;
    logic [31:0] x_miss;
    logic [31:0] x_hit;
  } vec_t;

  function automatic vec_t mkv(bit nrst, bit ren, logic [31:0] addr, bit w, logic [31:0] ld,
                               bit xh, bit xr, logic [31:0] xa, logic [31:0] xl,
                               logic [31:0] xm, logic [31:0] xc);
    vec_t v;
    v.nrst = nrst; v.ren = ren; v.addr = addr; v.w = w; v.ld = ld;
    v.x_ihit = xh; v.x_iren = xr; v.x_iaddr = xa; v.x_load = xl; v.x_miss = xm; v.x_hit = xc;
    return v;
  endfunction

  vec_t tbl [25];

  initial begin
    longint hit_base;
    bit     ren, rst_n, w;
    logic [31:0] addr;

    tbl[0]  = mkv(1, 1, 32'h040, 1, 32'h0,        0, 0, 32'h000, 32'h0,        0, 0);
    tbl[1]  = mkv(1, 1, 32'h040, 1, 32'h0,        0, 1, 32'h040, 32'h0,        1, 0);
    tbl[2]  = mkv(1, 1, 32'h040, 1, 32'h0,        0, 1, 32'h040, 32'h0,        1, 0);
    tbl[3]  = mkv(1, 1, 32'h040, 1, 32'h0,        0, 1, 32'h040, 32'h0,        1, 0);
    tbl[4]  = mkv(1, 1, 32'h040, 0, 32'hDEADBEEF, 0, 1, 32'h040, 32'h0,        1, 0);
    tbl[5]  = mkv(1, 1, 32'h040, 1, 32'h0,        1, 0, 32'h000, 32'hDEADBEEF, 1, 0);
    tbl[6]  = mkv(1, 1, 32'h080, 1, 32'h0,        0, 0, 32'h000, 32'h0,        1, 1);
    tbl[7]  = mkv(1, 1, 32'h080, 0, 32'h11111111, 0, 1, 32'h080, 32'h0,        2, 1);
    tbl[8]  = mkv(1, 1, 32'h080, 1, 32'h0,        1, 0, 32'h000, 32'h11111111, 2, 1);
    tbl[9]  = mkv(1, 1, 32'h040, 1, 32'h0,        0, 0, 32'h000, 32'h0,        2, 2);
    tbl[10] = mkv(1, 1, 32'h040, 0, 32'hDEADBEEF, 0, 1, 32'h040, 32'h0,        3, 2);
    tbl[11] = mkv(1, 1, 32'h040, 1, 32'h0,        1, 0, 32'h000, 32'hDEADBEEF, 3, 2);
    tbl[12] = mkv(1, 0, 32'h040, 1, 32'h0,        0, 0, 32'h000, 32'h0,        3, 3);
    tbl[13] = mkv(1, 1, 32'h100, 1, 32'h0,        0, 0, 32'h000, 32'h0,        3, 3);
    tbl[14] = mkv(1, 1, 32'h104, 1, 32'h0,        0, 1, 32'h100, 32'h0,        4, 3);
    tbl[15] = mkv(1, 1, 32'h104, 0, 32'hCAFEF00D, 0, 1, 32'h100, 32'h0,        4, 3);
    tbl[16] = mkv(1, 1, 32'h104, 1, 32'h0,        0, 0, 32'h000, 32'h0,        4, 3);
    tbl[17] = mkv(1, 1, 32'h104, 0, 32'h0BADC0DE, 0, 1, 32'h104, 32'h0,        5, 3);
    tbl[18] = mkv(1, 1, 32'h100, 1, 32'h0,        1, 0, 32'h000, 32'hCAFEF00D, 5, 3);
    tbl[19] = mkv(1, 1, 32'h104, 1, 32'h0,        1, 0, 32'h000, 32'h0BADC0DE, 5, 4);
    tbl[20] = mkv(1, 1, 32'h200, 1, 32'h0,        0, 0, 32'h000, 32'h0,        5, 5);
    tbl[21] = mkv(0, 1, 32'h200, 1, 32'h0,        0, 1, 32'h200, 32'h0,        6, 5);
    tbl[22] = mkv(1, 1, 32'h104, 1, 32'h0,        0, 0, 32'h000, 32'h0,        0, 0);
    tbl[23] = mkv(1, 0, 32'h104, 0, 32'h12345678, 0, 1, 32'h104, 32'h0,        1, 0);
    tbl[24] = mkv(1, 1, 32'h104, 1, 32'h0,        1, 0, 32'h000, 32'h12345678, 1, 0);

    // Clock/reset
    nRST = 1'b0; bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    cycle(0, 1, 32'h040, 1, 32'h0);

    // Directed vectors
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].nrst, tbl[i].ren, tbl[i].addr, tbl[i].w, tbl[i].ld);
      check_model();
      chk($sformatf("vec%0d_ihit", i), {31'b0, bus.ihit}, {31'b0, tbl[i].x_ihit});
      chk($sformatf("vec%0d_iREN", i), {31'b0, bus.iREN}, {31'b0, tbl[i].x_iren});
      chk($sformatf("vec%0d_iaddr", i), bus.iaddr, tbl[i].x_iaddr);
      chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, tbl[i].x_miss);
      chk($sformatf("vec%0d_hit_cnt", i), hit_cnt, tbl[i].x_hit);
      if (tbl[i].x_ihit) chk($sformatf("vec%0d_imemload", i), bus.imemload, tbl[i].x_load);
      advance();
    end

    // Fill 0x00..0x3C, then sweep: every lookup hits, no controller traffic
    for (int i = 0; i < 16; i++) begin
      cycle(1, 1, 32'(i * 4), 1, 32'h0);
      cycle(1, 1, 32'(i * 4), 0, mem_word(32'(i * 4)));
    end
    hit_base = m_hits;
    for (int i = 0; i < 16; i++) begin
      apply(1, 1, 32'(i * 4), 1, 32'h0);
      check_model();
      chk("streak_ihit", {31'b0, bus.ihit}, 32'd1);
      chk("streak_iREN", {31'b0, bus.iREN}, 32'd0);
      chk("streak_load", bus.imemload, mem_word(32'(i * 4)));
      advance();
    end
    chk("streak_hit_cnt", hit_cnt, 32'(hit_base + 16));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) cycle(1, 1, 32'(i * 4), 1, 32'h0);
    chk("sat_hit_cnt_F", {28'b0, hit_cnt_s}, 32'h0000000F);

    // Random traffic with random controller latency and occasional reset
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      ren   = ($urandom_range(0, 9) < 8);
      addr  = {24'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) addr[31:28] = 4'($urandom_range(1, 15));
      w     = ($urandom_range(0, 2) != 0);
      cycle(rst_n, ren, addr, w, w ? 32'($urandom) : mem_word(m_faddr));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
